// File: rtl/fifo_pkg.sv
// Shared helpers for multi_lane_fifo: modular pointer advance, count width and transfer-count type.
package fifo_pkg;

  localparam int unsigned XFER_W = 8;

  typedef logic [XFER_W-1:0] xfer_t;

  function automatic int unsigned cnt_w(input int unsigned size);
    return $clog2(size + 1);
  endfunction

  // One conditional subtract is enough because inc never exceeds size.
  function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned inc,
                                          input int unsigned size);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= size) ? sum - size : sum;
  endfunction

endpackage

// File: rtl/multi_lane_fifo_mem.sv
// Register-array storage: PAR_WRITE indexed write ports, PAR_READ combinational read ports.
module multi_lane_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE       = 16,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned PTR_W      = 4
) (
  input  logic                                 clk,
  input  logic [PAR_WRITE-1:0]                 i_wr_en,
  input  logic [PTR_W-1:0]                     i_wptr,
  input  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0]                     i_rptr,
  output logic [PAR_READ-1:0][DATA_WIDTH-1:0]  o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [SIZE];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      if (i_wr_en[i]) r_mem[PTR_W'(ptr_add(32'(i_wptr), i, SIZE))] <= i_wr_data[i];
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int unsigned i = 0; i < PAR_READ; i++) begin
      o_rd_data[i] = r_mem[PTR_W'(ptr_add(32'(i_rptr), i, SIZE))];
    end
  end

endmodule

// File: rtl/multi_lane_fifo.sv
// Multi-lane FWFT FIFO with variable per-cycle lane counts on both sides.
// Optional almost_full/almost_empty outputs enabled by FIFO_ALMOST_FLAGS_EN.
module multi_lane_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE       = 16,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 1
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int unsigned AF_THRESH  = SIZE - 1,
  parameter int unsigned AE_THRESH  = 1
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic [$clog2(PAR_WRITE+1)-1:0]       wr_num,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  output logic [PAR_READ-1:0][DATA_WIDTH-1:0]  rd_data,
  input  logic [$clog2(PAR_READ+1)-1:0]        rd_num,
  input  logic                                 rd_ready,
  output logic                                 rd_valid,
  output logic [$clog2(SIZE+1)-1:0]            count,
  output logic                                 full,
  output logic                                 empty
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                                 almost_full,
  output logic                                 almost_empty
`endif
);

  localparam int unsigned CNT_W = cnt_w(SIZE);
  localparam int unsigned PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_free;
  logic                 w_wr_legal;
  logic                 w_rd_legal;
  logic                 w_push;
  logic                 w_pop;
  xfer_t                w_push_n;
  xfer_t                w_pop_n;
  logic [PAR_WRITE-1:0] w_wr_en;

  // Handshakes use only pre-edge state so push and pop never depend on each other.
  assign w_free     = CNT_W'(SIZE) - r_count;
  assign w_wr_legal = 32'(wr_num) <= PAR_WRITE;
  assign w_rd_legal = 32'(rd_num) <= PAR_READ;
  assign wr_ready   = w_wr_legal && (32'(w_free) >= 32'(wr_num));
  assign rd_valid   = w_rd_legal && (32'(r_count) >= 32'(rd_num));
  assign w_push     = wr_valid && wr_ready;
  assign w_pop      = rd_ready && rd_valid;
  assign w_push_n   = w_push ? XFER_W'(wr_num) : '0;
  assign w_pop_n    = w_pop ? XFER_W'(rd_num) : '0;

  always_comb begin
    w_wr_en = '0;
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      w_wr_en[i] = w_push && (i < 32'(wr_num));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= PTR_W'(ptr_add(32'(r_wptr), 32'(w_push_n), SIZE));
      if (w_pop)  r_rptr <= PTR_W'(ptr_add(32'(r_rptr), 32'(w_pop_n), SIZE));
      r_count <= CNT_W'(32'(r_count) + 32'(w_push_n) - 32'(w_pop_n));
    end
  end

  multi_lane_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .PAR_WRITE  (PAR_WRITE),
    .PAR_READ   (PAR_READ),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wptr    (r_wptr),
    .i_wr_data (wr_data),
    .i_rptr    (r_rptr),
    .o_rd_data (rd_data)
  );

  assign count = r_count;
  assign full  = (r_count == CNT_W'(SIZE));
  assign empty = (r_count == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = 32'(r_count) >= AF_THRESH;
  assign almost_empty = 32'(r_count) <= AE_THRESH;
`endif

endmodule
